// File: rtl/snn_pkg.sv
// Shared constants and types for the spiking-network datapath (LIF and STDP blocks).
package snn_pkg;

   localparam int W_WIDTH = 8;
   localparam int T_WIDTH = 4;
   localparam int T_WIN   = 15;

   typedef logic [W_WIDTH-1:0] weight_t;
   typedef logic [T_WIDTH-1:0] stdp_time_t;

   localparam weight_t    W_INIT    = weight_t'(64);
   localparam weight_t    W_MAX     = weight_t'(255);
   localparam weight_t    W_MIN     = weight_t'(0);
   localparam stdp_time_t T_WIN_VAL = stdp_time_t'(T_WIN);

endpackage

// File: rtl/stdp_spike_timer.sv
// Saturating cycles-since-spike timer. It reads T_WIN after reset, which means
// "no recent spike". A spike reloads it to 1 on the following edge.
module stdp_spike_timer
   import snn_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               spike,
   output logic [T_WIDTH-1:0] t
);

   // Reload on a spike, otherwise count up and stop at the window edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         t <= T_WIN_VAL;
      end else if (spike) begin
         t <= stdp_time_t'(1);
      end else if (t < T_WIN_VAL) begin
         t <= t + stdp_time_t'(1);
      end
   end

endmodule

// File: rtl/stdp_synapse_array.sv
// Plastic synapse stage. It holds one weight per presynaptic input and produces a
// saturated weighted current for the post neuron. Each weight is updated by
// pair-based STDP, using per-synapse pre timers and a shared post timer.
module stdp_synapse_array
   import snn_pkg::*;
#(
   parameter int N_SYN     = 5,
   parameter int LTP_SHIFT = 0,
   parameter int LTD_SHIFT = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_SYN-1:0]   pre_spike,
   input  logic               post_spike,
   input  logic               learn_en,
   output logic [W_WIDTH-1:0] syn_current,
   output logic               w_update,
   input  logic [2:0]         w_sel,
   output logic [W_WIDTH-1:0] w_rd
);

   logic [W_WIDTH-1:0] weight [N_SYN];
   logic [W_WIDTH-1:0] w_next [N_SYN];
   logic [T_WIDTH-1:0] pre_t  [N_SYN];
   logic [T_WIDTH-1:0] post_t;
   logic [W_WIDTH:0]   ltp_d  [N_SYN];
   logic [W_WIDTH:0]   ltp_sum[N_SYN];
   logic [W_WIDTH:0]   ltd_d  [N_SYN];
   logic [W_WIDTH+2:0] acc;
   logic               any_change;

   for (genvar g = 0; g < N_SYN; g++) begin : g_pre_timer
      stdp_spike_timer u_pre_timer (
         .clk   (clk),
         .rst   (rst),
         .spike (pre_spike[g]),
         .t     (pre_t[g])
      );
   end

   stdp_spike_timer u_post_timer (
      .clk   (clk),
      .rst   (rst),
      .spike (post_spike),
      .t     (post_t)
   );

   // Next weight per synapse. The timers still hold their pre-edge values here,
   // so dt is measured before any reload on this edge.
   always_comb begin
      any_change = 1'b0;
      for (int i = 0; i < N_SYN; i++) begin
         w_next[i]  = weight[i];
         ltp_d[i]   = (W_WIDTH+1)'((T_WIN_VAL - pre_t[i]) >> LTP_SHIFT);
         ltd_d[i]   = (W_WIDTH+1)'((T_WIN_VAL - post_t) >> LTD_SHIFT);
         ltp_sum[i] = {1'b0, weight[i]} + ltp_d[i];
         if (learn_en) begin
            if (post_spike && !pre_spike[i] && (pre_t[i] < T_WIN_VAL)) begin
               if (ltp_sum[i] > {1'b0, W_MAX}) w_next[i] = W_MAX;
               else                            w_next[i] = ltp_sum[i][W_WIDTH-1:0];
            end else if (pre_spike[i] && !post_spike && (post_t < T_WIN_VAL)) begin
               if ({1'b0, weight[i]} >= ({1'b0, W_MIN} + ltd_d[i]))
                  w_next[i] = weight[i] - ltd_d[i][W_WIDTH-1:0];
               else
                  w_next[i] = W_MIN;
            end
         end
         if (w_next[i] != weight[i]) any_change = 1'b1;
      end
   end

   // Weighted sum of the spiking inputs. The accumulator has 3 spare bits so that
   // the sum cannot wrap before saturation is applied.
   always_comb begin
      acc = '0;
      for (int i = 0; i < N_SYN; i++) begin
         if (pre_spike[i]) acc = acc + {3'b000, weight[i]};
      end
   end

   // Weight storage and the change pulse. All synapses commit on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_SYN; i++) weight[i] <= W_INIT;
         w_update <= 1'b0;
      end else begin
         for (int i = 0; i < N_SYN; i++) weight[i] <= w_next[i];
         w_update <= any_change;
      end
   end

   // Registered, saturated current toward the post neuron.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         syn_current <= '0;
      end else if (acc > (W_WIDTH+3)'({W_WIDTH{1'b1}})) begin
         syn_current <= {W_WIDTH{1'b1}};
      end else begin
         syn_current <= acc[W_WIDTH-1:0];
      end
   end

   // Debug readout. Out-of-range selects read as zero.
   always_comb begin
      w_rd = '0;
      for (int i = 0; i < N_SYN; i++) begin
         if (w_sel == 3'(i)) w_rd = weight[i];
      end
   end

endmodule

// File: tb/tb_stdp_synapse_array.sv
// Bench for stdp_synapse_array. Each scenario starts from a fresh reset.
`timescale 1ns/100ps
module tb_stdp_synapse_array;

   localparam int W     = 8;
   localparam int N     = 5;
   localparam int TW    = 15;
   localparam int WINIT = 64;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] pre_spike = '0;
   logic         post_spike = 1'b0;
   logic         learn_en = 1'b1;
   logic [W-1:0] syn_current;
   logic         w_update;
   logic [2:0]   w_sel = 3'd0;
   logic [W-1:0] w_rd;

   logic [W-1:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   stdp_synapse_array dut (
      .clk         (clk),
      .rst         (rst),
      .pre_spike   (pre_spike),
      .post_spike  (post_spike),
      .learn_en    (learn_en),
      .syn_current (syn_current),
      .w_update    (w_update),
      .w_sel       (w_sel),
      .w_rd        (w_rd)
   );

   // Clock and reset.
   always #5 clk = ~clk;

   task automatic apply_reset();
      rst = 1'b1;
      pre_spike = '0;
      post_spike = 1'b0;
      learn_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   // Driver. Inputs change 1ns after the edge, and outputs are read back at that same point.
   task automatic drive(input logic [N-1:0] p, input logic q);
      pre_spike = p;
      post_spike = q;
      @(posedge clk); #1;
      pre_spike = '0;
      post_spike = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive('0, 1'b0);
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      for (int s = 0; s < 8; s++) begin
         exp_q.push_back((s < N) ? W'(WINIT) : W'(0));
         w_sel = 3'(s); #0.5;
         n_cmp++;
         if (w_rd !== exp_q[0]) begin
            n_err++; $display("FAIL reset_w_rd sel=%0d got=%0d exp=%0d", s, w_rd, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
      n_cmp++;
      if (syn_current !== 8'd0) begin n_err++; $display("FAIL reset_current got=%0d exp=0", syn_current); end
      n_cmp++;
      if (w_update !== 1'b0) begin n_err++; $display("FAIL reset_w_update got=%0b exp=0", w_update); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_ltp();
      int pulses;
      apply_reset();
      pulses = 0;
      drive(5'b00001, 1'b0); pulses += int'(w_update);
      idle(2);               pulses += int'(w_update);
      exp_q.push_back(W'(WINIT + (TW - 3)));
      drive(5'b00000, 1'b1);
      n_cmp++;
      if (w_update !== 1'b1) begin n_err++; $display("FAIL ltp_w_update got=%0b exp=1", w_update); end
      idle(1); pulses += int'(w_update);
      n_cmp++;
      if (pulses !== 0) begin n_err++; $display("FAIL ltp_extra_pulses got=%0d exp=0", pulses); end
      w_sel = 3'd0; #0.5;
      n_cmp++;
      if (w_rd !== exp_q[0]) begin n_err++; $display("FAIL ltp_weight0 got=%0d exp=%0d", w_rd, exp_q[0]); end
      void'(exp_q.pop_front());
      for (int s = 1; s < N; s++) begin
         w_sel = 3'(s); #0.5;
         n_cmp++;
         if (w_rd !== W'(WINIT)) begin n_err++; $display("FAIL ltp_other sel=%0d got=%0d exp=%0d", s, w_rd, WINIT); end
      end
   endtask

   task automatic test_ltd();
      apply_reset();
      drive(5'b00000, 1'b1);
      idle(4);
      exp_q.push_back(W'(WINIT - ((TW - 5) >> 1)));
      drive(5'b00010, 1'b0);
      w_sel = 3'd1; #0.5;
      n_cmp++;
      if (w_rd !== exp_q[0]) begin n_err++; $display("FAIL ltd_weight1 got=%0d exp=%0d", w_rd, exp_q[0]); end
      void'(exp_q.pop_front());
   endtask

   task automatic test_current();
      logic [N-1:0] pats[3];
      logic [N-1:0] p;
      int sum;
      apply_reset();
      pats[0] = 5'b11111; pats[1] = 5'b00011; pats[2] = 5'b00000;
      for (int k = 0; k < 9; k++) begin
         p = (k < 3) ? pats[k] : N'($urandom_range(0, 31));
         sum = 0;
         for (int i = 0; i < N; i++) if (p[i]) sum += WINIT;
         exp_q.push_back((sum > 255) ? W'(255) : W'(sum));
         drive(p, 1'b0);
         n_cmp++;
         if (syn_current !== exp_q[0]) begin
            n_err++; $display("FAIL current pre=%b got=%0d exp=%0d", p, syn_current, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
   endtask

   task automatic test_ltp_clamp();
      int e;
      apply_reset();
      e = WINIT;
      for (int k = 1; k <= 15; k++) begin
         e = (e + (TW - 1) > 255) ? 255 : e + (TW - 1);
         exp_q.push_back(W'(e));
         drive(5'b00001, 1'b0);
         drive(5'b00000, 1'b1);
         n_cmp++;
         if (w_update !== ((k <= 14) ? 1'b1 : 1'b0)) begin
            n_err++; $display("FAIL ltp_clamp_w_update k=%0d got=%0b", k, w_update);
         end
         w_sel = 3'd0; #0.5;
         n_cmp++;
         if (w_rd !== exp_q[0]) begin n_err++; $display("FAIL ltp_clamp k=%0d got=%0d exp=%0d", k, w_rd, exp_q[0]); end
         void'(exp_q.pop_front());
         idle(16);
      end
   endtask

   task automatic test_ltd_clamp();
      int e;
      apply_reset();
      e = WINIT;
      for (int k = 1; k <= 11; k++) begin
         e = (e < ((TW - 1) >> 1)) ? 0 : e - ((TW - 1) >> 1);
         exp_q.push_back(W'(e));
         drive(5'b00000, 1'b1);
         drive(5'b00001, 1'b0);
         n_cmp++;
         if (w_update !== ((k <= 10) ? 1'b1 : 1'b0)) begin
            n_err++; $display("FAIL ltd_clamp_w_update k=%0d got=%0b", k, w_update);
         end
         w_sel = 3'd0; #0.5;
         n_cmp++;
         if (w_rd !== exp_q[0]) begin n_err++; $display("FAIL ltd_clamp k=%0d got=%0d exp=%0d", k, w_rd, exp_q[0]); end
         void'(exp_q.pop_front());
         idle(16);
      end
   endtask

   task automatic test_misc();
      apply_reset();
      // Same-cycle pre and post on synapse 2.
      drive(5'b00100, 1'b1);
      n_cmp++;
      if (w_update !== 1'b0) begin n_err++; $display("FAIL same_cycle_w_update got=%0b exp=0", w_update); end
      w_sel = 3'd2; #0.5;
      n_cmp++;
      if (w_rd !== W'(WINIT)) begin n_err++; $display("FAIL same_cycle_weight2 got=%0d exp=%0d", w_rd, WINIT); end
      idle(16);
      // Frozen learning.
      learn_en = 1'b0;
      drive(5'b00001, 1'b0);
      drive(5'b00000, 1'b1);
      n_cmp++;
      if (w_update !== 1'b0) begin n_err++; $display("FAIL frozen_w_update got=%0b exp=0", w_update); end
      w_sel = 3'd0; #0.5;
      n_cmp++;
      if (w_rd !== W'(WINIT)) begin n_err++; $display("FAIL frozen_weight0 got=%0d exp=%0d", w_rd, WINIT); end
      learn_en = 1'b1;
      idle(16);
      // Change weight 0 and 1, then assert reset between edges.
      drive(5'b00001, 1'b0);
      drive(5'b00000, 1'b1);
      drive(5'b00010, 1'b0);
      #2 rst = 1'b1;
      for (int s = 0; s < N; s++) begin
         w_sel = 3'(s); #0.5;
         n_cmp++;
         if (w_rd !== W'(WINIT)) begin n_err++; $display("FAIL async_reset sel=%0d got=%0d exp=%0d", s, w_rd, WINIT); end
      end
      n_cmp++;
      if (syn_current !== 8'd0 || w_update !== 1'b0) begin
         n_err++; $display("FAIL async_reset_outputs cur=%0d upd=%0b exp=0/0", syn_current, w_update);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_ltp();
      test_ltd();
      test_current();
      test_ltp_clamp();
      test_ltd_clamp();
      test_misc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
